issue_ctrl: RTL and testbench
=============================

# issue_ctrl

The issue controller sits between the decode stage and execute. It decides each cycle whether the instruction held in ID may issue, must stall, or must be flushed. It keeps a per-register scoreboard of pending writes, bounds the number of issued-but-unretired instructions, drains the pipeline for fence/fence.i, and sequences the IF/ID flush window after a taken branch or jump resolves in EX.

## Interface
Parameters:
- INFLIGHT_MAX, 4, maximum issued-not-retired instructions (1..15)
- FLUSH_CYCLES, 2, cycles flush_id stays high per redirect, counting the redirect cycle (1..7)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a decoded instruction
- id_rs1_ena / id_rs2_ena  in  1  source register read enables from decode
- id_rs1_addr / id_rs2_addr  in  5  source register addresses
- id_rd_ena  in  1  destination write enable
- id_rd_addr  in  5  destination address
- id_fence  in  1  ID instruction is fence or fence.i
- ex_redirect  in  1  branch/jump taken resolved in EX this cycle
- wb_valid  in  1  one issued instruction retires this cycle
- wb_rd_ena  in  1  the retiring instruction wrote a register
- wb_rd_addr  in  5  its destination
- issue_fire  out  1  ID instruction issues into EX this cycle
- stall_if  out  1  hold PC and IF/ID register
- stall_id  out  1  hold ID/EX input (insert bubble)
- flush_id  out  1  invalidate IF/ID contents
- inflight_cnt  out  4  issued-not-retired count
- ctrl_state  out  2  00 RUN, 01 DRAIN, 10 FLUSH
- proto_err  out  1  sticky; set when wb_valid arrives with inflight_cnt==0

## Operation
- Scoreboard pend[31:1]. pend[0] is always 0.
- wb_clr: wb_valid & wb_rd_ena & wb_rd_addr!=0.
- Effective pend for hazard checks is pend & ~(wb_clr at wb_rd_addr). A same-cycle writeback is bypassed.
- raw = (rs1_ena & rs1!=0 & pend_eff[rs1]) | (rs2_ena & rs2!=0 & pend_eff[rs2]).
- waw = rd_ena & rd!=0 & pend_eff[rd].
- full = (inflight_cnt==INFLIGHT_MAX) & ~wb_valid.
- issue_fire = RUN & id_valid & ~ex_redirect & ~raw & ~waw & ~full & ~(id_fence & inflight_cnt!=0).
- On issue_fire with rd_ena & rd!=0: set pend[rd].
  - On wb_clr: clear pend[wb_rd_addr].
  - Same register set and cleared in one cycle: set wins.
- inflight_cnt_next = inflight_cnt + issue_fire − wb_valid. If wb_valid with cnt==0 and no issue, cnt holds 0 and proto_err sets.
- flush_id = ex_redirect | (state==FLUSH).
- stall_if = stall_id = id_valid & ~issue_fire & ~flush_id.
- State transitions, with ex_redirect taking priority in every state:
  - ex_redirect: if FLUSH_CYCLES>1, go to FLUSH and load fcnt=FLUSH_CYCLES−1; otherwise go to RUN.
  - RUN: id_valid & id_fence & inflight_cnt!=0 goes to DRAIN.
  - DRAIN: no issue. When inflight_cnt_next==0, go to RUN; the fence issues in the following cycle.
  - FLUSH: fcnt decrements each cycle; fcnt==1 goes to RUN. A redirect inside FLUSH reloads fcnt.
  - A redirect in DRAIN abandons the drain, because the fence is flushed.
- Flushes do not touch the scoreboard or the count. Issued instructions are older than the redirecting one and still retire.

## Timing
- Hazard, full, issue and stall decisions are combinational in the same cycle. The scoreboard, count, state, fcnt and proto_err are registered.
- Reset (rst low, asynchronous) values: pend=0, inflight_cnt=0, ctrl_state=RUN, fcnt=0, proto_err=0.
  - issue_fire, stall_if, stall_id and flush_id are forced to 0 while rst is low.
- Issue-to-dependent latency: a dependent instruction may issue in the cycle its producer's wb_valid is seen, with zero bubbles beyond writeback.
- A redirect produces exactly FLUSH_CYCLES consecutive cycles of flush_id=1 with issue_fire=0.

## Test plan
- RAW stall and bypass:
  - Stimulus: issue rd=5; next ID instruction reads rs1=5; hold wb_valid low for 3 cycles, then wb_valid with wb_rd_addr=5.
  - Required: stall_id=1 for 3 cycles, then issue_fire=1 in the wb_valid cycle and pend[5] cleared.
- x0 and set-wins:
  - Stimulus (x0): an instruction with rd=0 issues, then a reader of rs1=0 follows.
  - Required: no stall.
  - Stimulus (set-wins): issue rd=7 in the same cycle a wb clears x7.
  - Required: pend[7]=1 afterwards.
- Credit limit:
  - Stimulus: issue 4 independent instructions with no wb.
  - Required: inflight_cnt=4, the 5th stalls. A wb_valid in the 5th cycle lets it issue that cycle, and cnt stays 4.
- Fence drain:
  - Stimulus: with cnt=2, id_fence arrives.
  - Required: ctrl_state=DRAIN and stalls. After 2 wb_valid pulses, state returns to RUN and the fence issues the next cycle.
- Redirect:
  - Stimulus: ex_redirect with FLUSH_CYCLES=2, then a second redirect during FLUSH.
  - Required: flush_id high for 2 cycles, extended by reload. No issue occurs, and the scoreboard is unchanged.
  - Stimulus: redirect during DRAIN.
  - Required: state goes to FLUSH.
- Reset/protocol:
  - Stimulus: assert rst mid-DRAIN with pend bits set.
  - Required: all state clears asynchronously and outputs read 0.
  - Stimulus: wb_valid with cnt=0.
  - Required: proto_err=1 and remains set until reset.

Source files
------------

// File: rtl/issue_ctrl.sv
// Issue controller between decode and execute: scoreboard-based RAW/WAW
// hazard checks, an in-flight credit limit, fence drain and the redirect flush window.
module issue_ctrl #(
    parameter int unsigned INFLIGHT_MAX = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic       id_rs1_ena,
    input  logic       id_rs2_ena,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_rd_ena,
    input  logic [4:0] id_rd_addr,
    input  logic       id_fence,
    input  logic       ex_redirect,
    input  logic       wb_valid,
    input  logic       wb_rd_ena,
    input  logic [4:0] wb_rd_addr,
    output logic       issue_fire,
    output logic       stall_if,
    output logic       stall_id,
    output logic       flush_id,
    output logic [3:0] inflight_cnt,
    output logic [1:0] ctrl_state,
    output logic       proto_err
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t      state;
    logic [2:0]  fcnt;
    logic [31:0] pend;
    logic [31:0] pend_eff;
    logic [31:0] clr_mask;
    logic [31:0] set_mask;
    logic [31:0] pend_next;
    logic [3:0]  cnt_next;
    logic        wb_clr;
    logic        raw;
    logic        waw;
    logic        full;
    logic        fence_block;
    logic        fire;
    logic        flush;

    assign wb_clr = wb_valid & wb_rd_ena & (wb_rd_addr != 5'd0);

    always_comb begin
        clr_mask = '0;
        if (wb_clr) clr_mask[wb_rd_addr] = 1'b1;
    end

    // A writeback landing this cycle is already visible to the hazard check.
    assign pend_eff = pend & ~clr_mask;

    assign raw = (id_rs1_ena & (id_rs1_addr != 5'd0) & pend_eff[id_rs1_addr])
               | (id_rs2_ena & (id_rs2_addr != 5'd0) & pend_eff[id_rs2_addr]);
    assign waw = id_rd_ena & (id_rd_addr != 5'd0) & pend_eff[id_rd_addr];

    assign full        = (inflight_cnt == 4'(INFLIGHT_MAX)) & ~wb_valid;
    assign fence_block = id_fence & (inflight_cnt != 4'd0);

    assign fire  = (state == RUN) & id_valid & ~ex_redirect & ~raw & ~waw
                 & ~full & ~fence_block;
    assign flush = ex_redirect | (state == FLUSH);

    assign issue_fire = rst & fire;
    assign flush_id   = rst & flush;
    assign stall_id   = rst & id_valid & ~fire & ~flush;
    assign stall_if   = stall_id;

    always_comb begin
        set_mask = '0;
        if (fire && id_rd_ena && (id_rd_addr != 5'd0)) set_mask[id_rd_addr] = 1'b1;
        pend_next    = (pend & ~clr_mask) | set_mask;
        pend_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = inflight_cnt;
        case ({fire, wb_valid})
            2'b10:   cnt_next = inflight_cnt + 4'd1;
            2'b01:   cnt_next = (inflight_cnt == 4'd0) ? 4'd0 : inflight_cnt - 4'd1;
            default: cnt_next = inflight_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            fcnt         <= '0;
            pend         <= '0;
            inflight_cnt <= '0;
            proto_err    <= 1'b0;
        end else begin
            pend         <= pend_next;
            inflight_cnt <= cnt_next;
            if (wb_valid && (inflight_cnt == 4'd0)) proto_err <= 1'b1;

            if (ex_redirect) begin
                if (FLUSH_CYCLES > 1) begin
                    state <= FLUSH;
                    fcnt  <= 3'(FLUSH_CYCLES - 1);
                end else begin
                    state <= RUN;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (id_valid && id_fence && (inflight_cnt != 4'd0)) state <= DRAIN;
                    end
                    DRAIN: begin
                        if (cnt_next == 4'd0) state <= RUN;
                    end
                    FLUSH: begin
                        fcnt <= fcnt - 3'd1;
                        if (fcnt == 3'd1) state <= RUN;
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

    assign ctrl_state = state;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios plus random traffic, checked against
// an in-order queue model of issued instructions.
module tb_issue_ctrl;

    localparam int unsigned MAXQ = 4;
    localparam int unsigned FC   = 2;

    logic       clk;
    logic       rst;
    logic       id_valid, id_rs1_ena, id_rs2_ena, id_rd_ena, id_fence;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic       ex_redirect, wb_valid, wb_rd_ena;
    logic [4:0] wb_rd_addr;
    logic       issue_fire, stall_if, stall_id, flush_id, proto_err;
    logic [3:0] inflight_cnt;
    logic [1:0] ctrl_state;

    issue_ctrl #(.INFLIGHT_MAX(MAXQ), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_ena(id_rs1_ena), .id_rs2_ena(id_rs2_ena),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_ena(id_rd_ena), .id_rd_addr(id_rd_addr), .id_fence(id_fence),
        .ex_redirect(ex_redirect), .wb_valid(wb_valid), .wb_rd_ena(wb_rd_ena),
        .wb_rd_addr(wb_rd_addr), .issue_fire(issue_fire), .stall_if(stall_if),
        .stall_id(stall_id), .flush_id(flush_id), .inflight_cnt(inflight_cnt),
        .ctrl_state(ctrl_state), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Model: destinations of issued-not-retired instructions, oldest first.
    logic [4:0] q[$];
    bit         draining;
    int         flush_left;
    bit         perr;

    logic       o_fire, o_stall, o_flush, o_perr;
    logic [3:0] o_cnt;
    logic [1:0] o_state;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit busy(input logic [4:0] r, input bit wclr, input logic [4:0] wa);
        if (r == 5'd0) return 1'b0;
        if (wclr && wa == r) return 1'b0;
        foreach (q[i]) if (q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        q.delete();
        draining   = 1'b0;
        flush_left = 0;
        perr       = 1'b0;
    endfunction

    task automatic step(input string tag, input bit v, input bit r1e, input logic [4:0] r1,
                        input bit r2e, input logic [4:0] r2, input bit rde, input logic [4:0] rd,
                        input bit fen, input bit redir, input bit wbv);
        bit wclr, raw, waw, full, run, e_fire, e_flush, e_stall;
        int cnt_before;
        logic [1:0] e_state;
        id_valid = v; id_rs1_ena = r1e; id_rs1_addr = r1; id_rs2_ena = r2e; id_rs2_addr = r2;
        id_rd_ena = rde; id_rd_addr = rd; id_fence = fen; ex_redirect = redir; wb_valid = wbv;
        if (wbv && q.size() > 0) begin
            wb_rd_ena  = (q[0] != 5'd0);
            wb_rd_addr = q[0];
        end else begin
            wb_rd_ena  = 1'($urandom_range(0, 1));
            wb_rd_addr = 5'($urandom_range(0, 31));
        end
        #1;
        cnt_before = q.size();
        wclr    = wbv && wb_rd_ena && wb_rd_addr != 5'd0;
        raw     = (r1e && busy(r1, wclr, wb_rd_addr)) || (r2e && busy(r2, wclr, wb_rd_addr));
        waw     = rde && busy(rd, wclr, wb_rd_addr);
        full    = (cnt_before == MAXQ) && !wbv;
        run     = (flush_left == 0) && !draining;
        e_fire  = run && v && !redir && !raw && !waw && !full && !(fen && cnt_before != 0);
        e_flush = redir || flush_left > 0;
        e_stall = v && !e_fire && !e_flush;
        e_state = (flush_left > 0) ? 2'b10 : (draining ? 2'b01 : 2'b00);
        o_fire = issue_fire; o_stall = stall_id; o_flush = flush_id;
        o_cnt = inflight_cnt; o_state = ctrl_state; o_perr = proto_err;
        chk({tag, ".issue_fire"}, 4'(issue_fire), 4'(e_fire));
        chk({tag, ".stall_id"}, 4'(stall_id), 4'(e_stall));
        chk({tag, ".stall_if"}, 4'(stall_if), 4'(e_stall));
        chk({tag, ".flush_id"}, 4'(flush_id), 4'(e_flush));
        chk({tag, ".inflight_cnt"}, inflight_cnt, 4'(cnt_before));
        chk({tag, ".ctrl_state"}, 4'(ctrl_state), 4'(e_state));
        chk({tag, ".proto_err"}, 4'(proto_err), 4'(perr));
        @(posedge clk);
        if (wbv) begin
            if (q.size() > 0) void'(q.pop_front());
            else perr = 1'b1;
        end
        if (e_fire) q.push_back(rde ? rd : 5'd0);
        if (redir) begin
            flush_left = int'(FC) - 1;
            draining   = 1'b0;
        end else if (flush_left > 0) begin
            flush_left--;
        end else if (draining) begin
            if (q.size() == 0) draining = 1'b0;
        end else if (v && fen && cnt_before != 0) begin
            draining = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".issue_fire"}, 4'(issue_fire), 4'd0);
        chk({tag, ".stall_id"}, 4'(stall_id), 4'd0);
        chk({tag, ".stall_if"}, 4'(stall_if), 4'd0);
        chk({tag, ".flush_id"}, 4'(flush_id), 4'd0);
        chk({tag, ".inflight_cnt"}, inflight_cnt, 4'd0);
        chk({tag, ".ctrl_state"}, 4'(ctrl_state), 4'd0);
        chk({tag, ".proto_err"}, 4'(proto_err), 4'd0);
    endtask

    task automatic retire(input int n);
        for (int i = 0; i < n; i++) step("retire", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b0;
        id_valid = 1'b1; id_rs1_ena = 1'b1; id_rs1_addr = 5'd3; id_rs2_ena = 1'b0; id_rs2_addr = 5'd0;
        id_rd_ena = 1'b1; id_rd_addr = 5'd4; id_fence = 1'b0; ex_redirect = 1'b1;
        wb_valid = 1'b0; wb_rd_ena = 1'b0; wb_rd_addr = 5'd0;
        model_reset();
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b1;

        // RAW stall, then issue in the producer's writeback cycle
        step("raw_prod", 1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        chk("raw_prod.fire", 4'(o_fire), 4'd1);
        for (int i = 0; i < 3; i++) begin
            step("raw_wait", 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
            chk("raw_wait.stall", 4'(o_stall), 4'd1);
        end
        step("raw_bypass", 1, 1, 5, 0, 0, 0, 0, 0, 0, 1);
        chk("raw_bypass.fire", 4'(o_fire), 4'd1);
        step("raw_clear", 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_clear.fire", 4'(o_fire), 4'd1);
        retire(2);

        // x0 is never pending
        step("x0_prod", 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("x0_read", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("x0_read.fire", 4'(o_fire), 4'd1);
        chk("x0_read.stall", 4'(o_stall), 4'd0);
        retire(2);

        // set wins over same-cycle clear
        step("sw_prod", 1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        step("sw_same", 1, 0, 0, 0, 0, 1, 7, 0, 0, 1);
        chk("sw_same.fire", 4'(o_fire), 4'd1);
        step("sw_check", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        chk("sw_check.stall", 4'(o_stall), 4'd1);
        retire(1);

        // credit limit
        for (int i = 1; i <= 4; i++) step("cr_fill", 1, 0, 0, 0, 0, 1, 5'(i), 0, 0, 0);
        step("cr_full", 1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
        chk("cr_full.cnt", o_cnt, 4'd4);
        chk("cr_full.stall", 4'(o_stall), 4'd1);
        step("cr_wb", 1, 0, 0, 0, 0, 1, 10, 0, 0, 1);
        chk("cr_wb.fire", 4'(o_fire), 4'd1);
        step("cr_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("cr_after.cnt", o_cnt, 4'd4);
        retire(4);

        // fence drain
        step("fn_a", 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step("fn_b", 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        step("fn_arrive", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("fn_arrive.stall", 4'(o_stall), 4'd1);
        step("fn_drain1", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        chk("fn_drain1.state", 4'(o_state), 4'd1);
        chk("fn_drain1.stall", 4'(o_stall), 4'd1);
        step("fn_drain2", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        chk("fn_drain2.state", 4'(o_state), 4'd1);
        step("fn_issue", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("fn_issue.state", 4'(o_state), 4'd0);
        chk("fn_issue.fire", 4'(o_fire), 4'd1);
        retire(1);

        // redirect with a second redirect inside the flush window
        step("rd_prod", 1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        step("rd_redir", 1, 0, 0, 0, 0, 1, 11, 0, 1, 0);
        chk("rd_redir.flush", 4'(o_flush), 4'd1);
        chk("rd_redir.fire", 4'(o_fire), 4'd0);
        step("rd_again", 1, 0, 0, 0, 0, 1, 11, 0, 1, 0);
        chk("rd_again.state", 4'(o_state), 4'd2);
        chk("rd_again.flush", 4'(o_flush), 4'd1);
        step("rd_tail", 1, 0, 0, 0, 0, 1, 11, 0, 0, 0);
        chk("rd_tail.state", 4'(o_state), 4'd2);
        chk("rd_tail.fire", 4'(o_fire), 4'd0);
        step("rd_run", 1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        chk("rd_run.flush", 4'(o_flush), 4'd0);
        chk("rd_run.stall", 4'(o_stall), 4'd1);
        chk("rd_run.cnt", o_cnt, 4'd1);
        retire(1);

        // redirect during drain
        step("dr_prod", 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        step("dr_fence", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("dr_redir", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("dr_redir.state", 4'(o_state), 4'd1);
        step("dr_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("dr_flush.state", 4'(o_state), 4'd2);
        step("dr_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("dr_run.state", 4'(o_state), 4'd0);
        retire(1);

        // asynchronous reset in the middle of a drain
        step("rs_a", 1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        step("rs_b", 1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
        step("rs_fence", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("rs_drain", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("rs_drain.state", 4'(o_state), 4'd1);
        id_valid = 1'b1; id_fence = 1'b0; ex_redirect = 1'b1; wb_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_reset("rs_mid");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step("rs_after", 1, 1, 6, 1, 8, 0, 0, 0, 0, 0);
        chk("rs_after.fire", 4'(o_fire), 4'd1);
        retire(1);

        // writeback with nothing in flight
        step("pe_wb", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("pe_hold", 1, 0, 0, 0, 0, 1, 12, 0, 0, 0);
        chk("pe_hold.perr", 4'(o_perr), 4'd1);
        retire(1);

        for (int n = 0; n < 400; n++) begin
            bit v, wbv;
            v = ($urandom_range(0, 9) < 8);
            if (q.size() > 0) wbv = ($urandom_range(0, 9) < 4);
            else wbv = !v && ($urandom_range(0, 19) == 0);
            step("rand", v, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 15) == 0), wbv);
        end

        id_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk_reset("final_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
